token_embedder: RTL

TOKEN_EMBEDDER -- requirements
Module: token_embedder

---
 rtl/token_embedder.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/token_embedder.sv
// rtl/token_embedder.sv - streams embedding vectors for a list of token IDs (optional macro TOKEN_EMBEDDER_SKIP_ZERO_EN)
module token_embedder #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int EMB_DIM    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cs,
  input  logic [ADDR_WIDTH:0]                    num_tokens,
  output logic [ADDR_WIDTH-1:0]                  tok_addr,
  input  logic [DATA_WIDTH-1:0]                  tok_data,
  output logic [ADDR_WIDTH+$clog2(EMB_DIM)-1:0]  emb_addr,
  input  logic [DATA_WIDTH-1:0]                  emb_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done
);

  localparam int LOG = $clog2(EMB_DIM);
  localparam int EW  = (EMB_DIM > 1) ? LOG : 1;
  localparam int EAW = ADDR_WIDTH + LOG;
  localparam logic [EW-1:0]         E_MAX   = EW'(EMB_DIM - 1);
  localparam logic [ADDR_WIDTH:0]   MAX_TOK = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, TOK_RD, TOK_WAIT, EMB_RD, EMB_WAIT, EMIT, FIN} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_sat;
  logic [ADDR_WIDTH-1:0] t;
  logic [EW-1:0]         e;
  logic [ADDR_WIDTH-1:0] tok_id;
  logic [ADDR_WIDTH-1:0] id_in;
  logic                  t_last;
  logic                  e_last;
  logic                  unused_tok_bits;
`ifdef TOKEN_EMBEDDER_SKIP_ZERO_EN
  // An element is parked in out_data while we look ahead for another non-zero token.
  logic                  pend;
`endif

  // Embedding table address: token ID in the high bits, element index in the low bits.
  function automatic logic [EAW-1:0] elem_addr(input logic [ADDR_WIDTH-1:0] id_v,
                                               input logic [EW-1:0]         e_v);
    elem_addr = (EAW'(id_v) << LOG) | EAW'(e_v);
  endfunction

  assign id_in           = tok_data[ADDR_WIDTH-1:0];
  assign unused_tok_bits = ^tok_data[DATA_WIDTH-1:ADDR_WIDTH];
  assign count_sat       = (num_tokens > MAX_TOK) ? MAX_TOK : num_tokens;
  assign t_last          = ({1'b0, t} == count - 1'b1);
  assign e_last          = (e == E_MAX);
  assign tok_addr        = t;
  assign busy            = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (cs) state_next = (num_tokens == '0) ? FIN : TOK_RD;
      TOK_RD:   state_next = TOK_WAIT;
`ifdef TOKEN_EMBEDDER_SKIP_ZERO_EN
      TOK_WAIT: begin
        if (id_in == '0) begin
          if (t_last) state_next = pend ? EMIT : FIN;
          else        state_next = TOK_RD;
        end else begin
          state_next = pend ? EMIT : EMB_RD;
        end
      end
`else
      TOK_WAIT: state_next = EMB_RD;
`endif
      EMB_RD:   state_next = EMB_WAIT;
`ifdef TOKEN_EMBEDDER_SKIP_ZERO_EN
      EMB_WAIT: state_next = (e_last && !t_last) ? TOK_RD : EMIT;
`else
      EMB_WAIT: state_next = EMIT;
`endif
      EMIT: begin
        if (out_ready) begin
          if (out_last)    state_next = FIN;
`ifdef TOKEN_EMBEDDER_SKIP_ZERO_EN
          else             state_next = EMB_RD;
`else
          else if (e_last) state_next = TOK_RD;
          else             state_next = EMB_RD;
`endif
        end
      end
      FIN:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Datapath: indices, addresses and the output element register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      t         <= '0;
      e         <= '0;
      tok_id    <= '0;
      emb_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef TOKEN_EMBEDDER_SKIP_ZERO_EN
      pend      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cs) begin
            count     <= count_sat;
            t         <= '0;
            e         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef TOKEN_EMBEDDER_SKIP_ZERO_EN
            pend      <= 1'b0;
`endif
          end
        end
        TOK_WAIT: begin
          tok_id   <= id_in;
          emb_addr <= elem_addr(id_in, '0);
`ifdef TOKEN_EMBEDDER_SKIP_ZERO_EN
          if (id_in == '0) begin
            if (!t_last) begin
              t <= t + 1'b1;
            end else if (pend) begin
              // Nothing non-zero follows: the parked element is the final one.
              out_valid <= 1'b1;
              out_last  <= 1'b1;
              pend      <= 1'b0;
            end
          end else if (pend) begin
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            pend      <= 1'b0;
          end
`endif
        end
        EMB_WAIT: begin
          out_data <= emb_data;
`ifdef TOKEN_EMBEDDER_SKIP_ZERO_EN
          if (e_last && !t_last) begin
            pend <= 1'b1;
            t    <= t + 1'b1;
          end else begin
            out_valid <= 1'b1;
            out_last  <= e_last && t_last;
          end
`else
          out_valid <= 1'b1;
          out_last  <= e_last && t_last;
`endif
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (!out_last) begin
              if (!e_last) begin
                e        <= e + 1'b1;
                emb_addr <= elem_addr(tok_id, e + 1'b1);
              end else begin
                e <= '0;
`ifdef TOKEN_EMBEDDER_SKIP_ZERO_EN
                emb_addr <= elem_addr(tok_id, '0);
`else
                t <= t + 1'b1;
`endif
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Done pulses for exactly the cycle spent in FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= (state_next == FIN);
  end

endmodule
